// File: rtl/inv_sweep_pkg.sv
// Shared types and constants for the inverter sweep checker.
// No logic, no latency, no flow control.
package inv_sweep_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int NUM_DUT = 3;
    localparam int ERR_W   = 8;

endpackage

// File: rtl/inv_mismatch.sv
// Flags each inverter instance whose output differs from ~a (bit0=sv, bit1=v, bit2=vhd).
// Combinational, zero latency; no flow control.
module inv_mismatch
    import inv_sweep_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   y_sv,
    input  logic [WIDTH-1:0]   y_v,
    input  logic [WIDTH-1:0]   y_vhd,
    output logic [NUM_DUT-1:0] m
);

    logic [WIDTH-1:0] a_inv;

    assign a_inv = ~a;

    always_comb begin
        m    = '0;
        m[0] = (y_sv  != a_inv);
        m[1] = (y_v   != a_inv);
        m[2] = (y_vhd != a_inv);
    end

endmodule

// File: rtl/inv_sweep_checker.sv
// Sweeps a through every code for DWELL cycles each and checks three inverter outputs once per code.
// Results registered one edge after the compare cycle; start is ignored while a sweep runs.
module inv_sweep_checker
    import inv_sweep_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int DWELL  = 10,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   y_sv,
    input  logic [WIDTH-1:0]   y_v,
    input  logic [WIDTH-1:0]   y_vhd,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_count,
    output logic [WIDTH-1:0]   first_err_code,
    output logic [NUM_DUT-1:0] first_err_mask
);

    localparam logic [WIDTH-1:0] CODE_MAX   = '1;
    localparam logic [7:0]       DWELL_LAST = 8'(DWELL - 1);
    localparam logic [7:0]       SETTLE_CYC = 8'(SETTLE);
    localparam logic [ERR_W-1:0] ERR_SAT    = '1;

    state_t               state,     state_nxt;
    logic [WIDTH-1:0]     a_q,       a_nxt;
    logic [7:0]           dwell_cnt, dwell_nxt;
    logic [ERR_W-1:0]     err_q,     err_nxt;
    logic [WIDTH-1:0]     fcode_q,   fcode_nxt;
    logic [NUM_DUT-1:0]   fmask_q,   fmask_nxt;
    logic [NUM_DUT-1:0]   m;

    inv_mismatch #(.WIDTH(WIDTH)) u_mismatch (
        .a     (a_q),
        .y_sv  (y_sv),
        .y_v   (y_v),
        .y_vhd (y_vhd),
        .m     (m)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            a_q       <= '0;
            dwell_cnt <= '0;
            err_q     <= '0;
            fcode_q   <= '0;
            fmask_q   <= '0;
        end else begin
            state     <= state_nxt;
            a_q       <= a_nxt;
            dwell_cnt <= dwell_nxt;
            err_q     <= err_nxt;
            fcode_q   <= fcode_nxt;
            fmask_q   <= fmask_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        a_nxt     = a_q;
        dwell_nxt = dwell_cnt;
        err_nxt   = err_q;
        fcode_nxt = fcode_q;
        fmask_nxt = fmask_q;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = RUN;
                    a_nxt     = '0;
                    dwell_nxt = '0;
                    err_nxt   = '0;
                    fcode_nxt = '0;
                    fmask_nxt = '0;
                end
            end
            RUN: begin
                // err_q never returns to zero once set, so zero marks "no failure yet"
                if (dwell_cnt == SETTLE_CYC && m != '0) begin
                    if (err_q != ERR_SAT) begin
                        err_nxt = err_q + 1'b1;
                    end
                    if (err_q == '0) begin
                        fcode_nxt = a_q;
                        fmask_nxt = m;
                    end
                end
                if (dwell_cnt == DWELL_LAST) begin
                    if (a_q == CODE_MAX) begin
                        state_nxt = DONE;
                    end else begin
                        a_nxt     = a_q + 1'b1;
                        dwell_nxt = '0;
                    end
                end else begin
                    dwell_nxt = dwell_cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign a              = a_q;
    assign busy           = (state == RUN);
    assign done           = (state == DONE);
    assign pass           = (state == DONE) && (err_q == '0);
    assign err_count      = err_q;
    assign first_err_code = fcode_q;
    assign first_err_mask = fmask_q;

endmodule

// File: tb/tb_inv_sweep_checker.sv
// Drives inverter responses from a per-code fault table and checks sweep results against a table-derived model.
module tb_inv_sweep_checker;

    localparam int WIDTH = 4;
    localparam int DWELL = 10;
    localparam int NCODE = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] y_sv, y_v, y_vhd;
    logic             busy, done, pass;
    logic [7:0]       err_count;
    logic [WIDTH-1:0] first_err_code;
    logic [2:0]       first_err_mask;

    logic [WIDTH-1:0] xtbl [NCODE][3];
    logic             glitch_en = 1'b0;
    logic [WIDTH-1:0] a_q = '0;
    logic             busy_q = 1'b0;
    logic             gl;

    int n_checks = 0;
    int n_errs   = 0;

    inv_sweep_checker #(.WIDTH(WIDTH), .DWELL(DWELL), .SETTLE(1)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .a              (a),
        .y_sv           (y_sv),
        .y_v            (y_v),
        .y_vhd          (y_vhd),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_code (first_err_code),
        .first_err_mask (first_err_mask)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        a_q    <= a;
        busy_q <= busy;
    end

    // Glitch only in the first cycle of each code (code change or sweep start).
    always_comb begin
        gl    = glitch_en && ((a != a_q) || (busy && !busy_q));
        y_sv  = ~a ^ xtbl[a][0] ^ {{(WIDTH-1){1'b0}}, gl};
        y_v   = ~a ^ xtbl[a][1];
        y_vhd = ~a ^ xtbl[a][2];
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_tbl();
        for (int c = 0; c < NCODE; c++)
            for (int i = 0; i < 3; i++)
                xtbl[c][i] = '0;
    endtask

    task automatic set_stuck(input int inst, input logic [WIDTH-1:0] val);
        logic [WIDTH-1:0] cv;
        for (int c = 0; c < NCODE; c++) begin
            cv = WIDTH'(c);
            xtbl[c][inst] = (~cv) ^ val;
        end
    endtask

    task automatic model(output int ec, output int fc, output int fm);
        int m;
        ec = 0; fc = 0; fm = 0;
        for (int c = 0; c < NCODE; c++) begin
            m = 0;
            for (int i = 0; i < 3; i++)
                if (xtbl[c][i] != '0) m = m | (1 << i);
            if (m != 0) begin
                if (ec == 0) begin
                    fc = c;
                    fm = m;
                end
                if (ec < 255) ec++;
            end
        end
    endtask

    task automatic sweep(input bit hold, output int cyc, output int bad);
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        cyc = 0;
        bad = 0;
        while (busy && cyc < 400) begin
            if (int'(a) != cyc / DWELL) bad++;
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic run_and_check(input string tag);
        int cyc, bad, ec, fc, fm;
        model(ec, fc, fm);
        sweep(1'b0, cyc, bad);
        check({tag, ".busy_cycles"}, cyc, NCODE * DWELL);
        check({tag, ".a_seq_bad"}, bad, 0);
        check({tag, ".done"}, int'(done), 1);
        check({tag, ".a_hold"}, int'(a), NCODE - 1);
        check({tag, ".err_count"}, int'(err_count), ec);
        check({tag, ".pass"}, int'(pass), (ec == 0) ? 1 : 0);
        check({tag, ".first_code"}, int'(first_err_code), fc);
        check({tag, ".first_mask"}, int'(first_err_mask), fm);
    endtask

    initial begin
        int cyc, bad, guard;
        clear_tbl();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst.busy", int'(busy), 0);
        check("rst.done", int'(done), 0);
        check("rst.pass", int'(pass), 0);
        check("rst.a", int'(a), 0);
        check("rst.err", int'(err_count), 0);
        check("rst.fcode", int'(first_err_code), 0);
        check("rst.fmask", int'(first_err_mask), 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle.busy", int'(busy), 0);

        run_and_check("ideal");

        clear_tbl(); set_stuck(1, 4'hF);
        run_and_check("v_stuckF");

        clear_tbl(); set_stuck(0, 4'h0); set_stuck(1, 4'h0); set_stuck(2, 4'h0);
        run_and_check("all_stuck0");

        clear_tbl(); xtbl[9][2] = 4'h1;
        run_and_check("vhd_a9");

        clear_tbl(); glitch_en = 1'b1;
        run_and_check("glitch_d0");
        glitch_en = 1'b0;

        for (int r = 0; r < 6; r++) begin
            clear_tbl();
            for (int c = 0; c < NCODE; c++)
                for (int i = 0; i < 3; i++)
                    if ($urandom_range(0, 9) == 0) xtbl[c][i] = WIDTH'($urandom_range(1, NCODE - 1));
            glitch_en = 1'(r & 1);
            run_and_check($sformatf("rand%0d", r));
        end
        glitch_en = 1'b0;

        // Reset mid-sweep after errors have accumulated.
        clear_tbl(); set_stuck(1, 4'hF);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (a != 4'd7 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("mid.reach_a7", int'(a), 7);
        check("mid.err_before", int'(err_count), 6);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid.a", int'(a), 0);
        check("mid.busy", int'(busy), 0);
        check("mid.done", int'(done), 0);
        check("mid.err", int'(err_count), 0);
        clear_tbl();
        run_and_check("after_rst");

        reset = 1'b1; start = 1'b1;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        check("rst_vs_start.busy", int'(busy), 0);
        check("rst_vs_start.done", int'(done), 0);

        // start held high for a whole sweep, then restart from DONE.
        clear_tbl(); set_stuck(1, 4'hF);
        sweep(1'b1, cyc, bad);
        check("hold.busy_cycles", cyc, NCODE * DWELL);
        check("hold.a_seq_bad", bad, 0);
        check("hold.done", int'(done), 1);
        check("hold.err", int'(err_count), 15);
        @(negedge clk);
        start = 1'b0;
        check("restart.done", int'(done), 0);
        check("restart.busy", int'(busy), 1);
        check("restart.a", int'(a), 0);
        check("restart.err", int'(err_count), 0);
        check("restart.fcode", int'(first_err_code), 0);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("final.busy", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
